my_alu: RTL and testbench
=========================

Name: my_alu

Overview:
- Registered WIDTH-bit (default 4) arithmetic/logic unit.
- Selects add, subtract, AND or OR on operands A and B via 2-bit opcode S.
- Result C and carry Co are registered on the clock edge; one-cycle latency.
- Small datapath leaf block inside the lab CPU/ALU datapath.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  A/B/S valid this cycle
- A  input  WIDTH  operand A, unsigned
- B  input  WIDTH  operand B, unsigned
- S  input  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 OR
- C  output  WIDTH  registered result
- Co  output  1  registered carry-out
- out_valid  output  1  C/Co hold the result of an accepted operation

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, at any time, including mid-operation):
  - C=0, Co=0, out_valid=0 immediately.
  - Any in-flight result is discarded.
- Accept: on a rising clk edge with in_valid=1, the result of the current A/B/S is loaded into C/Co and out_valid=1 on the next cycle. Latency is exactly 1 cycle.
- Hold: when in_valid=0, C/Co keep their last values and out_valid goes to 0 on the next edge.
- No backpressure; every valid-cycle input is accepted, so throughput is one op per cycle.
- ADD (00):
  - {Co,C} = A + B computed at WIDTH+1 bits.
  - Co is the carry out of the MSB; C wraps modulo 2^WIDTH.
- SUB (01):
  - {Co,C} = A + ~B + 1 at WIDTH+1 bits.
  - Co=1 means no borrow (A >= B); Co=0 means borrow, and C is the two's-complement wrap.
  - A == B gives C=0, Co=1.
- AND (10): C = A & B, Co=0.
- OR (11): C = A | B, Co=0.
- No X propagation: every opcode value is defined, and there is no default/illegal state.
- No state machine beyond the output registers.

Optional Feature:
- Macro MY_ALU_FLAGS_EN.
- When defined, two extra registered outputs are added, updated under the same accept/reset rules as C:
  - Z (1 bit): 1 when the result C is 0.
  - V (1 bit): signed overflow, meaningful for ADD/SUB only and 0 for AND/OR.
    - ADD: V set when the operands have the same sign and the result sign differs.
    - SUB: V set when the operands have different signs and the result sign differs from A.
- Both Z and V reset to 0.
- When not defined, the ports and logic are absent and the port list is exactly as above.

Decomposition:
- Package my_alu_pkg holds:
  - Opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11.
  - Typedef alu_op_t (2-bit).
- Sub-module my_alu_adder: WIDTH-bit ripple adder with inputs a, b, cin and outputs sum, cout.
  - Serves both ADD (b=B, cin=0) and SUB (b=~B, cin=1).
- Top level handles the opcode mux and output registers.

Test Plan:
- Reset: assert rst_n=0 mid-stream with in_valid=1 -> C=0, Co=0, out_valid=0 immediately; first result appears one cycle after release.
- ADD with carry: A=10, B=7, S=00, in_valid=1 -> next cycle C=1, Co=1, out_valid=1.
- ADD then SUB, back-to-back one per cycle:
  - A=10, B=3, S=00 -> C=13, Co=0.
  - Then S=01 -> C=7, Co=1.
- SUB with borrow: A=3, B=10, S=01 -> C=9, Co=0. A=5, B=5, S=01 -> C=0, Co=1.
- Logic ops:
  - A=10, B=3, S=10 -> C=2, Co=0.
  - S=11 -> C=11, Co=0.
  - Then drop in_valid -> C holds 11 and out_valid returns to 0.
- MY_ALU_FLAGS_EN:
  - A=7, B=1, S=00 -> C=8, V=1, Z=0.
  - A=5, B=5, S=01 -> Z=1, V=0.

Source files
------------

// File: rtl/my_alu_pkg.sv
// Shared definitions for the my_alu block: opcode type and opcode constants.
package my_alu_pkg;

   // 2-bit ALU opcode as carried on the S input.
   typedef logic [1:0] alu_op_t;

   localparam alu_op_t OP_ADD = 2'b00;
   localparam alu_op_t OP_SUB = 2'b01;
   localparam alu_op_t OP_AND = 2'b10;
   localparam alu_op_t OP_OR  = 2'b11;

endpackage

// File: rtl/my_alu_adder.sv
// WIDTH-bit ripple-carry adder shared by the ADD and SUB paths of my_alu.
// SUB is formed by the caller as a + ~b + 1 (b inverted, cin = 1).
module my_alu_adder #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic carry;

   // Ripple the carry from LSB to MSB one full-adder stage at a time.
   always_comb begin
      sum   = '0;
      carry = cin;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/my_alu.sv
// my_alu: registered WIDTH-bit ADD/SUB/AND/OR unit with one-cycle latency.
// Optional build macro MY_ALU_FLAGS_EN adds registered Z (zero) and
// V (signed overflow) outputs that follow the same accept/reset rules as C.
//
// Handshake: an operation is accepted on every rising clk edge where
// in_valid=1 (no backpressure). On the following cycle out_valid=1 and C/Co
// hold its result. When in_valid=0, C/Co keep their last value and
// out_valid drops to 0 after the next edge. rst_n clears everything at once.
module my_alu
   import my_alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       S,
   output logic [WIDTH-1:0] C,
   output logic             Co,
   output logic             out_valid
`ifdef MY_ALU_FLAGS_EN
   ,
   output logic             Z,
   output logic             V
`endif
);

   alu_op_t          op;
   logic             sub_sel;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] sum;
   logic             cout;

   logic [WIDTH-1:0] c_d, c_q;
   logic             co_d, co_q;
   logic             out_valid_q;

   assign op      = S;
   assign sub_sel = (op == OP_SUB);
   // Subtraction reuses the adder as A + ~B + 1.
   assign add_b   = sub_sel ? ~B : B;

   my_alu_adder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .a    (A),
      .b    (add_b),
      .cin  (sub_sel),
      .sum  (sum),
      .cout (cout)
   );

   // Opcode mux: arithmetic ops take the adder result, logic ops clear carry.
   always_comb begin
      c_d  = sum;
      co_d = cout;
      case (op)
         OP_ADD, OP_SUB: begin
            c_d  = sum;
            co_d = cout;
         end
         OP_AND: begin
            c_d  = A & B;
            co_d = 1'b0;
         end
         OP_OR: begin
            c_d  = A | B;
            co_d = 1'b0;
         end
         default: begin
            c_d  = sum;
            co_d = cout;
         end
      endcase
   end

   // Output registers: load on accept, hold otherwise; valid tracks in_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q         <= '0;
         co_q        <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            c_q  <= c_d;
            co_q <= co_d;
         end
      end
   end

   assign C         = c_q;
   assign Co        = co_q;
   assign out_valid = out_valid_q;

`ifdef MY_ALU_FLAGS_EN
   logic z_d, z_q;
   logic v_d, v_q;

   // Flags: zero on the muxed result; signed overflow for ADD/SUB only.
   // Using the effective adder operand makes one rule cover both ops:
   // overflow when A and add_b share a sign and the sum's sign differs.
   always_comb begin
      z_d = (c_d == '0);
      v_d = 1'b0;
      if (op == OP_ADD || op == OP_SUB) begin
         v_d = (A[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
   end

   // Flag registers share the accept/hold/reset behaviour of C.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z_q <= 1'b0;
         v_q <= 1'b0;
      end else if (in_valid) begin
         z_q <= z_d;
         v_q <= v_d;
      end
   end

   assign Z = z_q;
   assign V = v_q;
`endif

endmodule

// File: tb/tb_my_alu.sv
// Testbench for my_alu (WIDTH=4): directed vectors with hand-computed results,
// expected responses queued by the driver and checked by a separate monitor.
// Build with MY_ALU_FLAGS_EN defined to also check the Z/V outputs.
module tb_my_alu;

   localparam int WIDTH = 4;
   localparam int EW    = WIDTH + 3;   // packed {c, co, z, v}

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [1:0]       S;
   logic [WIDTH-1:0] C;
   logic             Co;
   logic             out_valid;
`ifdef MY_ALU_FLAGS_EN
   logic             Z;
   logic             V;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [EW-1:0] exp_q[$];

   my_alu #(
      .WIDTH (WIDTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .S         (S),
      .C         (C),
      .Co        (Co),
      .out_valid (out_valid)
`ifdef MY_ALU_FLAGS_EN
      ,
      .Z         (Z),
      .V         (V)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   // ---------------- checking helper ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_C"}, 32'(C), 32'd0);
      check({tag, "_Co"}, 32'(Co), 32'd0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
`ifdef MY_ALU_FLAGS_EN
      check({tag, "_Z"}, 32'(Z), 32'd0);
      check({tag, "_V"}, 32'(V), 32'd0);
`endif
   endtask

   // ---------------- driver tasks ----------------
   // Issue one operation on the next falling edge and queue its expected result.
   task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [1:0] s, input logic [WIDTH-1:0] c_exp,
                        input logic co_exp, input logic z_exp, input logic v_exp);
      @(negedge clk);
      A        = a;
      B        = b;
      S        = s;
      in_valid = 1'b1;
      exp_q.push_back({c_exp, co_exp, z_exp, v_exp});
   endtask

   // Idle cycle with scrambled operands to show the outputs hold.
   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      A        = WIDTH'($urandom_range(0, 15));
      B        = WIDTH'($urandom_range(0, 15));
      S        = 2'($urandom_range(0, 3));
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got out_valid=1 with C=%0d, expected no output", C);
         end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("result_C", 32'(C), 32'(e[EW-1:3]));
            check("result_Co", 32'(Co), 32'(e[2]));
`ifdef MY_ALU_FLAGS_EN
            check("result_Z", 32'(Z), 32'(e[1]));
            check("result_V", 32'(V), 32'(e[0]));
`endif
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      A        = '0;
      B        = '0;
      S        = 2'b00;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst_n = 1'b1;

      // ADD with carry: 10 + 7 = 17 -> C=1, Co=1
      drive(4'd10, 4'd7, 2'b00, 4'd1, 1'b1, 1'b0, 1'b0);
      // Back-to-back ADD then SUB
      drive(4'd10, 4'd3, 2'b00, 4'd13, 1'b0, 1'b0, 1'b0);
      drive(4'd10, 4'd3, 2'b01, 4'd7, 1'b1, 1'b0, 1'b1);
      // SUB with borrow, and equal operands
      drive(4'd3, 4'd10, 2'b01, 4'd9, 1'b0, 1'b0, 1'b1);
      drive(4'd5, 4'd5, 2'b01, 4'd0, 1'b1, 1'b1, 1'b0);
      // Logic ops
      drive(4'd10, 4'd3, 2'b10, 4'd2, 1'b0, 1'b0, 1'b0);
      drive(4'd10, 4'd3, 2'b11, 4'd11, 1'b0, 1'b0, 1'b0);
      idle();
      @(negedge clk);
      check("hold_C", 32'(C), 32'd11);
      check("hold_Co", 32'(Co), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd0);

      // Boundary / flag vectors
      drive(4'd7, 4'd1, 2'b00, 4'd8, 1'b0, 1'b0, 1'b1);
      drive(4'd15, 4'd15, 2'b00, 4'd14, 1'b1, 1'b0, 1'b0);
      drive(4'd0, 4'd1, 2'b01, 4'd15, 1'b0, 1'b0, 1'b0);
      drive(4'd0, 4'd0, 2'b01, 4'd0, 1'b1, 1'b1, 1'b0);
      drive(4'd12, 4'd3, 2'b10, 4'd0, 1'b0, 1'b1, 1'b0);
      drive(4'd8, 4'd1, 2'b01, 4'd7, 1'b1, 1'b0, 1'b1);
      drive(4'd5, 4'd10, 2'b11, 4'd15, 1'b0, 1'b0, 1'b0);

      // Mid-stream reset: result 6+1 is captured, then discarded by reset.
      drive(4'd6, 4'd1, 2'b00, 4'd7, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      A = 4'd9;
      B = 4'd9;
      #1;
      check_outputs_zero("midreset");
      repeat (2) @(negedge clk);
      check_outputs_zero("inreset");
      // Release with a valid op pending: result must appear one cycle later.
      A        = 4'd2;
      B        = 4'd3;
      S        = 2'b00;
      in_valid = 1'b1;
      rst_n    = 1'b1;
      exp_q.push_back({4'd5, 1'b0, 1'b0, 1'b0});
      #1;
      check("release_out_valid", 32'(out_valid), 32'd0);
      idle();
      idle();
      @(negedge clk);
      check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
